// File: rtl/his_reader.sv
// Purpose: drains a completed ping-pong histogram bank, streams each bin, tracks the per-pixel peak, and zeroes each bin once it is consumed.
// Latency: a bin is presented 2 cycles after its read strobe; each bin takes at least 4 cycles (ISSUE, WAIT, OUT, CLR), plus one PEAK cycle per pixel.
// Backpressure: the bin beat is held stable in OUT until binReady; the bin is not cleared until that beat has been accepted.
module his_reader #(
    parameter int NB      = 8,
    parameter int PIX_NUM = 2,
    parameter int PIX_W   = 1,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  hisNum,
    output logic                  ramBank,
    output logic [PIX_W+NB-1:0]   ramAddr,
    output logic                  ramRdEn,
    input  logic [CNT_W-1:0]      ramRdData,
    output logic                  ramClrEn,
    output logic                  binValid,
    input  logic                  binReady,
    output logic [CNT_W-1:0]      binData,
    output logic [NB-1:0]         binIdx,
    output logic [PIX_W-1:0]      binPixel,
    output logic                  binLast,
    output logic                  peakValid,
    output logic [NB-1:0]         peakIdx,
    output logic [CNT_W-1:0]      peakCount,
    output logic                  frameDone,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_CLR,
        S_PEAK,
        S_DONE
    } state_t;

    localparam logic [NB-1:0]    BIN_MAX = '1;
    localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(PIX_NUM - 1);

    state_t             state_q,      state_d;
    logic               his_num_q,    his_num_d;
    logic               ram_bank_q,   ram_bank_d;
    logic [PIX_W-1:0]   pixel_q,      pixel_d;
    logic [NB-1:0]      bin_q,        bin_d;
    logic [CNT_W-1:0]   bin_data_q,   bin_data_d;
    logic [NB-1:0]      bin_idx_q,    bin_idx_d;
    logic [PIX_W-1:0]   bin_pixel_q,  bin_pixel_d;
    logic               bin_last_q,   bin_last_d;
    logic [NB-1:0]      peak_idx_q,   peak_idx_d;
    logic [CNT_W-1:0]   peak_count_q, peak_count_d;
    logic               overrun_q,    overrun_d;

    logic               toggle;

    // A toggle of hisNum relative to its last sampled value marks the other bank complete.
    assign toggle = (hisNum != his_num_q);

    // Next-state, counters, beat capture, peak tracking and overrun detection.
    always_comb begin
        state_d      = state_q;
        his_num_d    = hisNum;
        ram_bank_d   = ram_bank_q;
        pixel_d      = pixel_q;
        bin_d        = bin_q;
        bin_data_d   = bin_data_q;
        bin_idx_d    = bin_idx_q;
        bin_pixel_d  = bin_pixel_q;
        bin_last_d   = bin_last_q;
        peak_idx_d   = peak_idx_q;
        peak_count_d = peak_count_q;
        overrun_d    = overrun_q;

        // A toggle during a readout is flagged but never restarts or disturbs it.
        if (state_q != S_IDLE && toggle) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (toggle) begin
                    // The previously written bank is the one that just completed.
                    ram_bank_d   = his_num_q;
                    pixel_d      = '0;
                    bin_d        = '0;
                    peak_idx_d   = '0;
                    peak_count_d = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Read data arrives exactly one cycle after the strobe.
                bin_data_d  = ramRdData;
                bin_idx_d   = bin_q;
                bin_pixel_d = pixel_q;
                bin_last_d  = (bin_q == BIN_MAX);
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (binReady) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                // Strict compare keeps the lowest index on ties.
                if (bin_data_q > peak_count_q) begin
                    peak_count_d = bin_data_q;
                    peak_idx_d   = bin_idx_q;
                end
                if (bin_q != BIN_MAX) begin
                    bin_d   = bin_q + NB'(1);
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_PEAK;
                end
            end
            S_PEAK: begin
                if (pixel_q != PIX_MAX) begin
                    pixel_d      = pixel_q + PIX_W'(1);
                    bin_d        = '0;
                    peak_idx_d   = '0;
                    peak_count_d = '0;
                    state_d      = S_ISSUE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any readout and re-syncs hisNum so leaving reset starts nothing.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= S_IDLE;
            his_num_q    <= hisNum;
            ram_bank_q   <= 1'b0;
            pixel_q      <= '0;
            bin_q        <= '0;
            bin_data_q   <= '0;
            bin_idx_q    <= '0;
            bin_pixel_q  <= '0;
            bin_last_q   <= 1'b0;
            peak_idx_q   <= '0;
            peak_count_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            his_num_q    <= his_num_d;
            ram_bank_q   <= ram_bank_d;
            pixel_q      <= pixel_d;
            bin_q        <= bin_d;
            bin_data_q   <= bin_data_d;
            bin_idx_q    <= bin_idx_d;
            bin_pixel_q  <= bin_pixel_d;
            bin_last_q   <= bin_last_d;
            peak_idx_q   <= peak_idx_d;
            peak_count_q <= peak_count_d;
            overrun_q    <= overrun_d;
        end
    end

    // Strobes decode straight from the registered state, so read and clear can never overlap.
    assign ramBank   = ram_bank_q;
    assign ramAddr   = {pixel_q, bin_q};
    assign ramRdEn   = (state_q == S_ISSUE);
    assign ramClrEn  = (state_q == S_CLR);
    assign binValid  = (state_q == S_OUT);
    assign binData   = bin_data_q;
    assign binIdx    = bin_idx_q;
    assign binPixel  = bin_pixel_q;
    assign binLast   = bin_last_q;
    assign peakValid = (state_q == S_PEAK);
    assign peakIdx   = peak_idx_q;
    assign peakCount = peak_count_q;
    assign frameDone = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_his_reader.sv
// Directed bench for his_reader: BRAM model with read latency 1, stream monitor, linear stimulus.
module tb_his_reader;

    localparam int NB      = 8;
    localparam int PIX_NUM = 2;
    localparam int PIX_W   = 1;
    localparam int CNT_W   = 16;
    localparam int AW      = PIX_W + NB;
    localparam int NADDR   = 1 << AW;

    logic              clk = 1'b0;
    logic              res;
    logic              hisNum;
    logic              ramBank;
    logic [AW-1:0]     ramAddr;
    logic              ramRdEn;
    logic [CNT_W-1:0]  ramRdData;
    logic              ramClrEn;
    logic              binValid;
    logic              binReady;
    logic [CNT_W-1:0]  binData;
    logic [NB-1:0]     binIdx;
    logic [PIX_W-1:0]  binPixel;
    logic              binLast;
    logic              peakValid;
    logic [NB-1:0]     peakIdx;
    logic [CNT_W-1:0]  peakCount;
    logic              frameDone;
    logic              busy;
    logic              overrun;

    his_reader #(.NB(NB), .PIX_NUM(PIX_NUM), .PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .res(res), .hisNum(hisNum),
        .ramBank(ramBank), .ramAddr(ramAddr), .ramRdEn(ramRdEn), .ramRdData(ramRdData),
        .ramClrEn(ramClrEn), .binValid(binValid), .binReady(binReady), .binData(binData),
        .binIdx(binIdx), .binPixel(binPixel), .binLast(binLast), .peakValid(peakValid),
        .peakIdx(peakIdx), .peakCount(peakCount), .frameDone(frameDone), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Requests from the stimulus to the memory model / monitor.
    logic              ld_vld = 1'b0;
    logic              ld_bank;
    logic [AW-1:0]     ld_addr;
    logic [CNT_W-1:0]  ld_val;
    logic              wipe = 1'b0;
    logic              cnt_rst = 1'b0;
    logic              frame_bank = 1'b0;

    // BRAM model: contents, reference copy of the loaded pattern, per-address clear counts.
    logic [CNT_W-1:0]  mem     [2][NADDR];
    logic [CNT_W-1:0]  ref_mem [2][NADDR];
    int                clr_cnt [2][NADDR];

    always @(posedge clk) begin
        if (ramRdEn) ramRdData <= mem[ramBank][ramAddr];
        if (ramClrEn) begin
            mem[ramBank][ramAddr] = '0;
            clr_cnt[ramBank][ramAddr] = clr_cnt[ramBank][ramAddr] + 1;
        end
        if (wipe) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < NADDR; a++) begin
                    mem[b][a] = '0;
                    ref_mem[b][a] = '0;
                end
            end
        end
        if (cnt_rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < NADDR; a++) clr_cnt[b][a] = 0;
            end
        end
        if (ld_vld) begin
            mem[ld_bank][ld_addr] = ld_val;
            ref_mem[ld_bank][ld_addr] = ld_val;
        end
    end

    // Stream monitor, sampled mid-cycle after the stimulus has driven its inputs.
    int                cyc = 0;
    int                last_acc = 0;
    int                n_bins = 0, ord_err = 0, data_err = 0, space_err = 0;
    int                n_peak = 0, n_done = 0, n_rd = 0, excl_err = 0;
    logic [PIX_W-1:0]  exp_pix = '0;
    logic [NB-1:0]     exp_idx = '0;
    logic [NB-1:0]     pk_idx [2];
    logic [CNT_W-1:0]  pk_cnt [2];
    logic [PIX_W-1:0]  pk_pix [2];

    always begin
        @(negedge clk);
        #2;
        cyc = cyc + 1;
        if (cnt_rst) begin
            n_bins = 0; ord_err = 0; data_err = 0; space_err = 0;
            n_peak = 0; n_done = 0; n_rd = 0; excl_err = 0;
            exp_pix = '0; exp_idx = '0;
            for (int i = 0; i < 2; i++) begin
                pk_idx[i] = '1; pk_cnt[i] = '1; pk_pix[i] = '1;
            end
        end else begin
            if (binValid && binReady) begin
                if (n_bins > 0 && (cyc - last_acc) != ((exp_idx == 0) ? 5 : 4)) space_err = space_err + 1;
                last_acc = cyc;
                if (binPixel !== exp_pix || binIdx !== exp_idx || binLast !== (exp_idx == 8'hFF))
                    ord_err = ord_err + 1;
                if (binData !== ref_mem[frame_bank][{exp_pix, exp_idx}]) data_err = data_err + 1;
                n_bins = n_bins + 1;
                if (exp_idx == 8'hFF) begin
                    exp_idx = '0;
                    exp_pix = exp_pix + 1'b1;
                end else begin
                    exp_idx = exp_idx + 8'd1;
                end
            end
            if (peakValid) begin
                if (n_peak < 2) begin
                    pk_idx[n_peak] = peakIdx;
                    pk_cnt[n_peak] = peakCount;
                    pk_pix[n_peak] = binPixel;
                end
                n_peak = n_peak + 1;
            end
            if (frameDone) n_done = n_done + 1;
            if (ramRdEn) n_rd = n_rd + 1;
            if (ramRdEn && ramClrEn) excl_err = excl_err + 1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, 64'({ramBank, ramAddr, ramRdEn, ramClrEn, binValid, binData,
                                binIdx, binPixel, binLast}), 64'd0);
        check({tag, "_b"}, 64'({peakValid, peakIdx, peakCount, frameDone, busy, overrun}), 64'd0);
    endtask

    task automatic poke(input logic b, input logic [AW-1:0] a, input logic [CNT_W-1:0] v);
        ld_bank = b; ld_addr = a; ld_val = v; ld_vld = 1'b1;
        @(negedge clk);
        ld_vld = 1'b0;
    endtask

    task automatic do_wipe();
        wipe = 1'b1;
        @(negedge clk);
        wipe = 1'b0;
    endtask

    task automatic do_cnt_rst();
        cnt_rst = 1'b1;
        @(negedge clk);
        cnt_rst = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (n_done == 0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(n_done > 0), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rd(input string tag);
        int k = 0;
        while (!ramRdEn && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(ramRdEn), 64'd1);
    endtask

    task automatic wait_bin(input logic [PIX_W-1:0] p, input logic [NB-1:0] i, input string tag);
        int k = 0;
        while (!(binValid && binPixel == p && binIdx == i) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(binValid && binPixel == p && binIdx == i), 64'd1);
    endtask

    task automatic clear_audit(input string tag, input logic b);
        int once = 0;
        int other = 0;
        int nz = 0;
        for (int a = 0; a < NADDR; a++) begin
            if (clr_cnt[b][a] == 1) once++;
            if (clr_cnt[!b][a] != 0) other++;
            if (mem[b][a] != '0) nz++;
        end
        check({tag, "_clr_once"}, 64'(once), 64'(NADDR));
        check({tag, "_clr_other"}, 64'(other), 64'd0);
        check({tag, "_bank_zero"}, 64'(nz), 64'd0);
    endtask

    initial begin
        res = 1'b1; hisNum = 1'b1; binReady = 1'b1;
        ld_bank = 1'b0; ld_addr = '0; ld_val = '0;

        // Reset with hisNum=1, then hold it for 50 cycles: nothing starts.
        repeat (3) @(negedge clk);
        check_zero("rst_outs");
        res = 1'b0;
        do_cnt_rst();
        repeat (50) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_nord", 64'(n_rd), 64'd0);
        check_zero("idle_outs");

        // Frame A: bank 0, pixel0 bins 5 and 200 tie at 9, pixel1 all zero.
        res = 1'b1; hisNum = 1'b0;
        repeat (2) @(negedge clk);
        res = 1'b0;
        do_wipe();
        poke(1'b0, 9'd5, 16'd9);
        poke(1'b0, 9'd200, 16'd9);
        frame_bank = 1'b0;
        do_cnt_rst();
        hisNum = 1'b1;
        wait_rd("a_start");
        check("a_bank", 64'(ramBank), 64'd0);
        check("a_addr0", 64'(ramAddr), 64'd0);
        wait_done("a_done");
        check("a_bins", 64'(n_bins), 64'd512);
        check("a_order", 64'(ord_err), 64'd0);
        check("a_data", 64'(data_err), 64'd0);
        check("a_spacing", 64'(space_err), 64'd0);
        check("a_npeak", 64'(n_peak), 64'd2);
        check("a_p0", 64'({pk_pix[0], pk_idx[0], pk_cnt[0]}), 64'({1'b0, 8'd5, 16'd9}));
        check("a_p1", 64'({pk_pix[1], pk_idx[1], pk_cnt[1]}), 64'({1'b1, 8'd0, 16'd0}));
        check("a_ndone", 64'(n_done), 64'd1);
        check("a_excl", 64'(excl_err), 64'd0);
        check("a_idle", 64'(busy), 64'd0);
        clear_audit("a", 1'b0);

        // Frame B: bank 1, backpressure on bin 3, saturated bin 7.
        do_wipe();
        poke(1'b1, 9'd3, 16'h1234);
        poke(1'b1, 9'd7, 16'hFFFF);
        frame_bank = 1'b1;
        do_cnt_rst();
        hisNum = 1'b0;
        wait_rd("b_start");
        check("b_bank", 64'(ramBank), 64'd1);
        wait_bin(1'b0, 8'd3, "b_bin3");
        binReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("b_hold_vld", 64'(binValid), 64'd1);
            check("b_hold_dat", 64'(binData), 64'h1234);
            check("b_hold_idx", 64'(binIdx), 64'd3);
            check("b_hold_noclr", 64'(ramClrEn), 64'd0);
        end
        binReady = 1'b1;
        wait_done("b_done");
        check("b_bins", 64'(n_bins), 64'd512);
        check("b_order", 64'(ord_err), 64'd0);
        check("b_data", 64'(data_err), 64'd0);
        check("b_p0", 64'({pk_pix[0], pk_idx[0], pk_cnt[0]}), 64'({1'b0, 8'd7, 16'hFFFF}));
        check("b_p1", 64'({pk_pix[1], pk_idx[1], pk_cnt[1]}), 64'({1'b1, 8'd0, 16'd0}));
        check("b_overrun", 64'(overrun), 64'd0);
        clear_audit("b", 1'b1);

        // Frame C: bank 0, toggle again at bin 100 -> sticky overrun, no restart.
        do_wipe();
        poke(1'b0, 9'd100, 16'h0010);
        poke(1'b0, 9'd101, 16'h0011);
        poke(1'b0, 9'h1FF, 16'h0042);
        frame_bank = 1'b0;
        do_cnt_rst();
        hisNum = 1'b1;
        wait_bin(1'b0, 8'd100, "c_bin100");
        hisNum = 1'b0;
        @(negedge clk);
        check("c_ovr_set", 64'(overrun), 64'd1);
        check("c_busy", 64'(busy), 64'd1);
        wait_done("c_done");
        check("c_bins", 64'(n_bins), 64'd512);
        check("c_order", 64'(ord_err), 64'd0);
        check("c_data", 64'(data_err), 64'd0);
        check("c_p0", 64'({pk_pix[0], pk_idx[0], pk_cnt[0]}), 64'({1'b0, 8'd101, 16'h0011}));
        check("c_p1", 64'({pk_pix[1], pk_idx[1], pk_cnt[1]}), 64'({1'b1, 8'd255, 16'h0042}));
        do_cnt_rst();
        repeat (30) @(negedge clk);
        check("c_norestart_rd", 64'(n_rd), 64'd0);
        check("c_norestart_busy", 64'(busy), 64'd0);
        check("c_ovr_sticky", 64'(overrun), 64'd1);

        // Frame D: reset at pixel 1 bin 50 aborts and clears overrun.
        do_wipe();
        frame_bank = 1'b0;
        do_cnt_rst();
        hisNum = 1'b1;
        wait_bin(1'b1, 8'd50, "d_bin50");
        res = 1'b1;
        @(negedge clk);
        check_zero("d_abort_outs");
        res = 1'b0;
        repeat (5) @(negedge clk);
        check("d_stay_idle", 64'(busy), 64'd0);

        // Frame E: a fresh toggle restarts from pixel 0, bin 0.
        do_wipe();
        poke(1'b1, 9'd0, 16'h0003);
        frame_bank = 1'b1;
        do_cnt_rst();
        hisNum = 1'b0;
        wait_rd("e_start");
        check("e_addr0", 64'(ramAddr), 64'd0);
        check("e_bank", 64'(ramBank), 64'd1);
        wait_done("e_done");
        check("e_bins", 64'(n_bins), 64'd512);
        check("e_order", 64'(ord_err), 64'd0);
        check("e_data", 64'(data_err), 64'd0);
        check("e_p0", 64'({pk_pix[0], pk_idx[0], pk_cnt[0]}), 64'({1'b0, 8'd0, 16'h0003}));
        check("e_overrun", 64'(overrun), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
